i2c_slave_read_responder: RTL and testbench
===========================================

Name: i2c_slave_read_responder

Overview:
Synthesizable I2C target (slave) answering the codebase's I2C read master at the other end of the same open-drain bus. Oversamples SCL/SDA on the system clock, detects START/STOP, matches a 7-bit address and ACKs it. On reads it shifts bytes out MSB-first from a local tx handshake; on writes it shifts bytes in and presents them on rx_data. It drives SDA only through an open-drain enable (sda_oe=1 pulls low), the same convention as the master.

Parameters:
SLAVE_ADDR, 7'h50, 7-bit address this target responds to
DEFAULT_BYTE, 8'hFF, byte sent when tx data is not available (stretch feature off)

Ports:
clk  input  1  system clock; SCL high and low phases each >= 4 clk
rst_n  input  1  asynchronous active-low reset
scl_i  input  1  bus SCL level (asynchronous to clk)
sda_i  input  1  bus SDA level (asynchronous to clk)
sda_oe  output  1  1 = pull SDA low, 0 = release
scl_oe  output  1  1 = hold SCL low (clock stretch); constant 0 without feature
tx_data  input  8  next byte to send on a read
tx_valid  input  1  tx_data is valid
tx_ready  output  1  1-cycle pulse: tx_data consumed into the shifter
rx_data  output  8  last byte received on a write
rx_valid  output  1  1-cycle pulse: rx_data updated
busy  output  1  high from address match to STOP or repeated START
rw  output  1  latched R/W bit of the current addressed transfer
tx_underrun  output  1  1-cycle pulse: DEFAULT_BYTE substituted

Behaviour:
- Reset: sda_oe=0, scl_oe=0, tx_ready=0, rx_data=8'h00, rx_valid=0, busy=0, rw=0, tx_underrun=0, state IDLE, bit counter 7.
- scl_i/sda_i pass through a 2-flop synchronizer plus one history flop; edges are detected on synchronized values (3-cycle detection latency).
- START: SDA fall while SCL high. STOP: SDA rise while SCL high. Both are honoured in every state, including mid-byte: START -> ADDR (repeated START), STOP -> IDLE. Either one releases sda_oe and scl_oe in the same cycle and drops busy.
- Data sampled on SCL rising edge; sda_oe changes only the cycle after a detected SCL falling edge.
- States: IDLE, ADDR, ADDR_ACK, TX_BYTE, TX_ACK, RX_BYTE, RX_ACK, WAIT_STOP.
- ADDR: shift 8 bits (7 addr + R/W). After the 8th rising edge: match -> latch rw, busy=1, ADDR_ACK. Mismatch -> WAIT_STOP, sda_oe never asserted.
- ADDR_ACK: sda_oe=1 for the whole 9th SCL low/high. On the 9th falling edge: rw=1 -> load byte, TX_BYTE. rw=0 -> release, RX_BYTE.
- Byte load (read): if tx_valid, shifter<=tx_data and tx_ready pulses once. Otherwise shifter<=DEFAULT_BYTE and tx_underrun pulses.
- TX_BYTE: sda_oe = ~shifter[bit]. Bit 7 is driven immediately on entry; later bits are driven after each falling edge. After the 8th falling edge release SDA -> TX_ACK.
- TX_ACK: sample SDA at the 9th rising edge. 0 (ACK) -> at falling edge load next byte, TX_BYTE. 1 (NACK) -> WAIT_STOP with SDA released.
- RX_BYTE: shift on 8 rising edges. At the 8th falling edge: rx_data updates, rx_valid pulses, sda_oe=1, RX_ACK. RX_ACK releases at the 9th falling edge -> RX_BYTE.
- WAIT_STOP: outputs released; wait for STOP (-> IDLE) or START (-> ADDR).
- Bit counter 3 bits, counts 7 down to 0 and wraps to 7 at each byte boundary.
- tx_ready/tx_underrun/rx_valid never assert together and never for more than one cycle.

Optional Feature:
Macro I2C_SLAVE_CLK_STRETCH_EN.
- With macro: when a byte load finds tx_valid=0, scl_oe=1 holds SCL low. The target stays in the load point until tx_valid, then loads, pulses tx_ready, drives bit 7, and releases scl_oe one cycle later. tx_underrun is never asserted. STOP, START, and reset all release scl_oe.
- Without macro: scl_oe is tied 0, and the DEFAULT_BYTE/tx_underrun path applies.

Decomposition:
- Package i2c_pkg: state encoding constants (3-bit, IDLE=0 ... WAIT_STOP=7), ACK=1'b0/NACK=1'b1 constants, default address constant.
- One sub-module, i2c_bus_sync: 2-flop synchronizer plus edge/START/STOP detector for SCL/SDA. Outputs scl_rise, scl_fall, start_det, stop_det, and synchronized sda.

Test Plan:
- Read 0x50, tx_data=8'hA5, tx_valid=1 -> ACK on 9th clock; bus bits 1,0,1,0,0,1,0,1; tx_ready pulses once; master NACK -> WAIT_STOP; STOP -> busy=0.
- Address 0x51 read -> sda_oe stays 0 throughout; busy stays 0; SDA high at 9th rising edge.
- Write 0x50 then data 8'h3C -> two ACKs; rx_data=8'h3C with one rx_valid pulse; rw=0.
- Two-byte read (8'h12 then 8'h34, master ACK after first) -> two tx_ready pulses, bytes in order; NACK after second.
- Repeated START after 4 bits of a read byte -> SDA released immediately; new address phase accepted. Separately, reset asserted mid-TX_BYTE -> all outputs at reset values asynchronously.
- tx_valid=0 at load: without macro -> 8'hFF sent and tx_underrun pulses. With I2C_SLAVE_CLK_STRETCH_EN -> scl_oe=1 until tx_valid rises; then 8'hA5 sent.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C read-responder target: state encoding,
// bus acknowledge levels and the default target address.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    TX_BYTE   = 3'd3,
    TX_ACK    = 3'd4,
    RX_BYTE   = 3'd5,
    RX_ACK    = 3'd6,
    WAIT_STOP = 3'd7
  } state_t;

  // SDA level seen by the transmitter during the 9th clock
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'h50;

  // Bits are counted 7 down to 0 within each byte
  localparam logic [2:0] BIT_CNT_INIT = 3'd7;

endpackage

// File: rtl/i2c_bus_sync.sv
// Bus front end: brings SCL/SDA into the clk domain through two flops,
// keeps one history flop and flags SCL edges plus START/STOP conditions.
module i2c_bus_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  // [0] metastability flop, [1] synchronized level, [2] previous level
  logic [2:0] scl_pipe_reg;
  logic [2:0] sda_pipe_reg;
  logic       scl_s;
  logic       scl_h;
  logic       sda_h;

  // Shift both lines through the synchronizer; the idle bus is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_pipe_reg <= 3'b111;
      sda_pipe_reg <= 3'b111;
    end else begin
      scl_pipe_reg <= {scl_pipe_reg[1:0], scl_i};
      sda_pipe_reg <= {sda_pipe_reg[1:0], sda_i};
    end
  end

  assign scl_s = scl_pipe_reg[1];
  assign scl_h = scl_pipe_reg[2];
  assign sda_s = sda_pipe_reg[1];
  assign sda_h = sda_pipe_reg[2];

  assign scl_rise  =  scl_s & ~scl_h;
  assign scl_fall  = ~scl_s &  scl_h;
  // SDA may only move while SCL is high for START/STOP
  assign start_det =  scl_s & scl_h &  sda_h & ~sda_s;
  assign stop_det  =  scl_s & scl_h & ~sda_h &  sda_s;

endmodule

// File: rtl/i2c_slave_read_responder.sv
// I2C target answering reads from a tx handshake and presenting written
// bytes on rx_data. Drives SDA/SCL only as open-drain pull-down enables.
// Optional clock stretching on empty tx data: I2C_SLAVE_CLK_STRETCH_EN.
module i2c_slave_read_responder
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR   = DEFAULT_SLAVE_ADDR,
  parameter logic [7:0] DEFAULT_BYTE = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic       scl_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       rw,
  output logic       tx_underrun
);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;
  logic bus_event;

  state_t     state_reg, state_next;
  logic [2:0] bit_cnt_reg, bit_cnt_next;
  logic [2:0] next_bit_idx;
  logic [7:0] shift_reg, shift_next;
  logic [7:0] rx_data_reg, rx_data_next;
  logic       sda_oe_reg, sda_oe_next;
  logic       scl_oe_reg, scl_oe_next;
  logic       stall_reg, stall_next;
  logic       rw_reg, rw_next;
  logic       busy_reg, busy_next;
  logic       tx_ready_reg, tx_ready_next;
  logic       rx_valid_reg, rx_valid_next;
  logic       underrun_reg, underrun_next;
  logic       load_req;

  i2c_bus_sync u_bus_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  assign bus_event    = start_det | stop_det;
  assign next_bit_idx = bit_cnt_reg - 3'd1;

  // START/STOP drop the bus drivers and busy in the very cycle they are seen
  assign sda_oe      = sda_oe_reg & ~bus_event;
  assign scl_oe      = scl_oe_reg & ~bus_event;  // never set unless stretching is built in
  assign busy        = busy_reg & ~bus_event;
  assign rw          = rw_reg;
  assign rx_data     = rx_data_reg;
  assign tx_ready    = tx_ready_reg;
  assign rx_valid    = rx_valid_reg;
  assign tx_underrun = underrun_reg;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= BIT_CNT_INIT;
      shift_reg    <= 8'h00;
      rx_data_reg  <= 8'h00;
      sda_oe_reg   <= 1'b0;
      scl_oe_reg   <= 1'b0;
      stall_reg    <= 1'b0;
      rw_reg       <= 1'b0;
      busy_reg     <= 1'b0;
      tx_ready_reg <= 1'b0;
      rx_valid_reg <= 1'b0;
      underrun_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      rx_data_reg  <= rx_data_next;
      sda_oe_reg   <= sda_oe_next;
      scl_oe_reg   <= scl_oe_next;
      stall_reg    <= stall_next;
      rw_reg       <= rw_next;
      busy_reg     <= busy_next;
      tx_ready_reg <= tx_ready_next;
      rx_valid_reg <= rx_valid_next;
      underrun_reg <= underrun_next;
    end
  end

  // Next-state, bit sequencing and byte load
  always_comb begin
    state_next    = state_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    rx_data_next  = rx_data_reg;
    sda_oe_next   = sda_oe_reg;
    scl_oe_next   = scl_oe_reg;
    stall_next    = stall_reg;
    rw_next       = rw_reg;
    busy_next     = busy_reg;
    tx_ready_next = 1'b0;
    rx_valid_next = 1'b0;
    underrun_next = 1'b0;
    load_req      = 1'b0;

    // SCL is let go one cycle after a stalled load has completed
    if (scl_oe_reg && !stall_reg) scl_oe_next = 1'b0;

    if (start_det) begin
      state_next   = ADDR;
      bit_cnt_next = BIT_CNT_INIT;
      sda_oe_next  = 1'b0;
      scl_oe_next  = 1'b0;
      stall_next   = 1'b0;
      busy_next    = 1'b0;
    end else if (stop_det) begin
      state_next   = IDLE;
      bit_cnt_next = BIT_CNT_INIT;
      sda_oe_next  = 1'b0;
      scl_oe_next  = 1'b0;
      stall_next   = 1'b0;
      busy_next    = 1'b0;
    end else begin
      case (state_reg)
        ADDR: begin
          if (scl_rise) begin
            shift_next   = {shift_reg[6:0], sda_s};
            bit_cnt_next = bit_cnt_reg - 3'd1;
            if (bit_cnt_reg == 3'd0) begin
              // shift_reg[6:0] already holds the 7 address bits; sda_s is R/W
              if (shift_reg[6:0] == SLAVE_ADDR) begin
                rw_next    = sda_s;
                busy_next  = 1'b1;
                state_next = ADDR_ACK;
              end else begin
                state_next = WAIT_STOP;
              end
            end
          end
        end
        ADDR_ACK: begin
          // First fall starts the ACK bit, second fall ends it
          if (stall_reg) begin
            load_req = 1'b1;
          end else if (scl_fall) begin
            if (!sda_oe_reg) begin
              sda_oe_next = ~ACK;
            end else if (rw_reg) begin
              load_req = 1'b1;
            end else begin
              sda_oe_next  = 1'b0;
              bit_cnt_next = BIT_CNT_INIT;
              state_next   = RX_BYTE;
            end
          end
        end
        TX_BYTE: begin
          if (scl_fall) begin
            bit_cnt_next = bit_cnt_reg - 3'd1;
            if (bit_cnt_reg == 3'd0) begin
              sda_oe_next = 1'b0;
              state_next  = TX_ACK;
            end else begin
              sda_oe_next = ~shift_reg[next_bit_idx];
            end
          end
        end
        TX_ACK: begin
          if (stall_reg) begin
            load_req = 1'b1;
          end else if (scl_rise && (sda_s == NACK)) begin
            state_next = WAIT_STOP;
          end else if (scl_fall) begin
            load_req = 1'b1;
          end
        end
        RX_BYTE: begin
          if (scl_rise) begin
            shift_next   = {shift_reg[6:0], sda_s};
            bit_cnt_next = bit_cnt_reg - 3'd1;
            if (bit_cnt_reg == 3'd0) state_next = RX_ACK;
          end
        end
        RX_ACK: begin
          // First fall publishes the byte and pulls ACK, second fall releases
          if (scl_fall) begin
            if (!sda_oe_reg) begin
              rx_data_next  = shift_reg;
              rx_valid_next = 1'b1;
              sda_oe_next   = ~ACK;
            end else begin
              sda_oe_next  = 1'b0;
              bit_cnt_next = BIT_CNT_INIT;
              state_next   = RX_BYTE;
            end
          end
        end
        default: ;
      endcase
    end

    if (load_req) begin
      if (tx_valid) begin
        shift_next    = tx_data;
        tx_ready_next = 1'b1;
        sda_oe_next   = ~tx_data[7];
        bit_cnt_next  = BIT_CNT_INIT;
        stall_next    = 1'b0;
        state_next    = TX_BYTE;
      end else begin
`ifdef I2C_SLAVE_CLK_STRETCH_EN
        // Hold SCL low and stay at the load point until data shows up
        stall_next  = 1'b1;
        scl_oe_next = 1'b1;
        sda_oe_next = 1'b0;
`else
        shift_next    = DEFAULT_BYTE;
        underrun_next = 1'b1;
        sda_oe_next   = ~DEFAULT_BYTE[7];
        bit_cnt_next  = BIT_CNT_INIT;
        state_next    = TX_BYTE;
`endif
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_read_responder.sv
// Directed bench for i2c_slave_read_responder: a bit-level I2C master
// drives an open-drain bus model; expected values are hand-computed.
module tb_i2c_slave_read_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       scl_bus, sda_bus;
  logic       sda_oe, scl_oe;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;
  logic       rw;
  logic       tx_underrun;

  int vectors = 0;
  int miscompares = 0;

  int tx_ready_cnt = 0, rx_valid_cnt = 0, underrun_cnt = 0, sda_oe_cyc = 0, pulse_err = 0;
  logic prev_tr = 1'b0, prev_rv = 1'b0, prev_ur = 1'b0;

  assign scl_bus = scl_m & ~scl_oe;
  assign sda_bus = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_read_responder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .scl_i       (scl_bus),
    .sda_i       (sda_bus),
    .sda_oe      (sda_oe),
    .scl_oe      (scl_oe),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .busy        (busy),
    .rw          (rw),
    .tx_underrun (tx_underrun)
  );

  // Pulse counters and exclusivity / single-cycle monitor
  always @(negedge clk) begin
    if (tx_ready)    tx_ready_cnt <= tx_ready_cnt + 1;
    if (rx_valid)    rx_valid_cnt <= rx_valid_cnt + 1;
    if (tx_underrun) underrun_cnt <= underrun_cnt + 1;
    if (sda_oe)      sda_oe_cyc   <= sda_oe_cyc + 1;
    if ((int'(tx_ready) + int'(rx_valid) + int'(tx_underrun)) > 1 ||
        (tx_ready && prev_tr) || (rx_valid && prev_rv) || (tx_underrun && prev_ur))
      pulse_err <= pulse_err + 1;
    prev_tr <= tx_ready;
    prev_rv <= rx_valid;
    prev_ur <= tx_underrun;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SCL period; returns the bus SDA level sampled mid-high
  task automatic bit_out(input logic b, output logic s);
    int k;
    tick(5);
    sda_m = b;
    tick(5);
    scl_m = 1'b1;
    k = 0;
    while (scl_bus !== 1'b1 && k < 400) begin
      tick(1);
      k++;
    end
    if (k >= 400) check("scl_release_timeout", 32'(scl_bus), 32'd1);
    tick(5);
    s = sda_bus;
    tick(5);
    scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    tick(5);
    scl_m = 1'b1;
    tick(8);
    sda_m = 1'b0;
    tick(8);
    scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    tick(5);
    scl_m = 1'b1;
    tick(8);
    sda_m = 1'b1;
    tick(8);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_out(d[i], s);
    bit_out(1'b1, ack);
  endtask

  task automatic read_byte(input logic master_ack, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_out(1'b1, s);
      d[i] = s;
    end
    bit_out(master_ack, s);
  endtask

  initial begin
    logic       ack;
    logic       s;
    logic [7:0] d;
    int         base_tr, base_rv, base_ur, base_oe;

    // Reset values
    tick(3);
    check("rst_sda_oe", 32'(sda_oe), 0);
    check("rst_scl_oe", 32'(scl_oe), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_rw", 32'(rw), 0);
    check("rst_rx_data", 32'(rx_data), 0);
    check("rst_pulses", 32'({tx_ready, rx_valid, tx_underrun}), 0);
    rst_n = 1'b1;
    tick(5);

    // Single-byte read of 0xA5, master NACK
    tx_data = 8'hA5; tx_valid = 1'b1;
    base_tr = tx_ready_cnt;
    i2c_start();
    write_byte(8'hA1, ack);
    check("rd_addr_ack", 32'(ack), 0);
    check("rd_busy", 32'(busy), 1);
    check("rd_rw", 32'(rw), 1);
    read_byte(1'b1, d);
    check("rd_data_a5", 32'(d), 32'hA5);
    check("rd_tx_ready_cnt", 32'(tx_ready_cnt - base_tr), 1);
    check("rd_nack_release", 32'(sda_oe), 0);
    i2c_stop();
    tick(4);
    check("rd_stop_busy", 32'(busy), 0);
    tx_valid = 1'b0;

    // Address mismatch 0x51
    base_oe = sda_oe_cyc;
    i2c_start();
    write_byte(8'hA3, ack);
    check("miss_ack_high", 32'(ack), 1);
    check("miss_busy", 32'(busy), 0);
    i2c_stop();
    check("miss_sda_oe_cyc", 32'(sda_oe_cyc - base_oe), 0);

    // Write 0x3C
    base_rv = rx_valid_cnt;
    i2c_start();
    write_byte(8'hA0, ack);
    check("wr_addr_ack", 32'(ack), 0);
    check("wr_rw", 32'(rw), 0);
    write_byte(8'h3C, ack);
    check("wr_data_ack", 32'(ack), 0);
    check("wr_rx_data", 32'(rx_data), 32'h3C);
    check("wr_rx_valid_cnt", 32'(rx_valid_cnt - base_rv), 1);
    i2c_stop();

    // Two-byte read 0x12, 0x34
    tx_data = 8'h12; tx_valid = 1'b1;
    base_tr = tx_ready_cnt;
    i2c_start();
    write_byte(8'hA1, ack);
    check("rd2_addr_ack", 32'(ack), 0);
    for (int i = 7; i >= 0; i--) begin
      bit_out(1'b1, s);
      d[i] = s;
    end
    tx_data = 8'h34;
    bit_out(1'b0, s);
    check("rd2_byte0", 32'(d), 32'h12);
    read_byte(1'b1, d);
    check("rd2_byte1", 32'(d), 32'h34);
    check("rd2_tx_ready_cnt", 32'(tx_ready_cnt - base_tr), 2);
    i2c_stop();

    // Repeated START after 4 bits of a read byte (0xC9: bit 3 is a 1)
    tx_data = 8'hC9;
    i2c_start();
    write_byte(8'hA1, ack);
    for (int i = 0; i < 4; i++) bit_out(1'b1, s);
    check("rs_busy_before", 32'(busy), 1);
    i2c_start();
    check("rs_sda_released", 32'(sda_oe), 0);
    check("rs_busy_dropped", 32'(busy), 0);
    tx_valid = 1'b0;
    write_byte(8'hA0, ack);
    check("rs_addr_ack", 32'(ack), 0);
    check("rs_rw", 32'(rw), 0);
    write_byte(8'h5A, ack);
    check("rs_rx_data", 32'(rx_data), 32'h5A);
    i2c_stop();

`ifdef I2C_SLAVE_CLK_STRETCH_EN
    // Empty tx at load: SCL stretched until data appears
    base_tr = tx_ready_cnt; base_ur = underrun_cnt;
    i2c_start();
    write_byte(8'hA1, ack);
    check("st_addr_ack", 32'(ack), 0);
    tick(20);
    check("st_scl_held", 32'(scl_oe), 1);
    tx_data = 8'hA5; tx_valid = 1'b1;
    tick(3);
    tx_valid = 1'b0;
    tick(3);
    check("st_scl_released", 32'(scl_oe), 0);
    read_byte(1'b1, d);
    check("st_data_a5", 32'(d), 32'hA5);
    check("st_tx_ready_cnt", 32'(tx_ready_cnt - base_tr), 1);
    check("st_underrun_cnt", 32'(underrun_cnt - base_ur), 0);
    i2c_stop();
`else
    // Empty tx at load: default byte substituted
    base_tr = tx_ready_cnt; base_ur = underrun_cnt;
    i2c_start();
    write_byte(8'hA1, ack);
    check("ur_addr_ack", 32'(ack), 0);
    read_byte(1'b1, d);
    check("ur_data_ff", 32'(d), 32'hFF);
    check("ur_underrun_cnt", 32'(underrun_cnt - base_ur), 1);
    check("ur_tx_ready_cnt", 32'(tx_ready_cnt - base_tr), 0);
    check("ur_scl_oe", 32'(scl_oe), 0);
    i2c_stop();
`endif

    // Asynchronous reset in the middle of TX_BYTE (0xA5, bit 4 = 0 driven)
    tx_data = 8'hA5; tx_valid = 1'b1;
    i2c_start();
    write_byte(8'hA1, ack);
    for (int i = 0; i < 3; i++) bit_out(1'b1, s);
    tick(8);
    check("ar_sda_driven", 32'(sda_oe), 1);
    #3 rst_n = 1'b0;
    #1;
    check("ar_sda_oe", 32'(sda_oe), 0);
    check("ar_busy", 32'(busy), 0);
    check("ar_rw", 32'(rw), 0);
    check("ar_rx_data", 32'(rx_data), 0);
    check("ar_scl_oe", 32'(scl_oe), 0);
    tick(2);
    rst_n = 1'b1;
    tx_valid = 1'b0;
    i2c_stop();
    tick(5);

    check("pulse_exclusive_single", 32'(pulse_err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute guard against a stuck run
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
